// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED-matrix scanner.
// Latency: none; holds only types, constants and pure functions.
// Backpressure: not applicable.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_t;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 8;
  localparam int DEF_DWELL       = 2048;
  localparam int DEF_BLANK       = 16;
  localparam int DEF_BRIGHT_BITS = 4;

  // Index/counter width for n states. A width is never allowed to be zero,
  // so a single-row matrix still gets a 1-bit row_idx.
  function automatic int width_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Converts an active-high "line is on" value to the pin level.
  function automatic logic pol_apply(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row timing for the scanner: blank/dwell down-counter plus the PWM phase counter.
// Latency: tc is combinational from the count; a load takes effect on the next CLK.
// Backpressure: none; follows the controls it is given every cycle.
// Ports: clr forces idle; load_blank/load_dwell start a window (load_dwell also zeroes
//        the PWM phase); pwm_run advances the phase; tc flags the last window cycle;
//        pwm_nxt is the phase the next cycle will hold.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int DWELL       = DEF_DWELL,
  parameter int BLANK       = DEF_BLANK,
  parameter int BRIGHT_BITS = DEF_BRIGHT_BITS
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   clr,
  input  logic                   load_blank,
  input  logic                   load_dwell,
  input  logic                   pwm_run,
  output logic                   tc,
  output logic [BRIGHT_BITS-1:0] pwm_nxt
);

  localparam int CW = width_of((DWELL > BLANK) ? DWELL : BLANK);

  logic [CW-1:0]          cnt;
  logic [BRIGHT_BITS-1:0] pwm_cnt;

  // Count reaches zero in the last cycle of a window, so a window loaded
  // with N-1 lasts exactly N cycles.
  assign tc = (cnt == '0);

  always_comb begin
    pwm_nxt = pwm_cnt;
    if (clr || load_dwell) pwm_nxt = '0;
    else if (pwm_run)      pwm_nxt = pwm_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_nxt;
      if (clr)             cnt <= '0;
      else if (load_dwell) cnt <= CW'(DWELL - 1);
      else if (load_blank) cnt <= CW'(BLANK - 1);
      else if (!tc)        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed ROWS x COLS LED scanner with blanking, global PWM and a double-buffered frame.
// Latency: all outputs registered; enable changes are seen on the lines one CLK later.
// Backpressure: frame_ready low while a frame waits in the shadow buffer; it frees at a frame boundary.
// Ports: enable starts/stops scanning; frame_data/frame_valid/frame_ready load the shadow
//        buffer; brightness sets duty; rows/columns drive the pins; row_idx is the current
//        row; frame_start pulses in the first blank cycle of row 0.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int   ROWS           = DEF_ROWS,
  parameter int   COLS           = DEF_COLS,
  parameter int   DWELL          = DEF_DWELL,
  parameter int   BLANK          = DEF_BLANK,
  parameter int   BRIGHT_BITS    = DEF_BRIGHT_BITS,
  parameter bit   ROW_ACTIVE_LOW = 1'b0,
  parameter bit   COL_ACTIVE_LOW = 1'b1,
  localparam int  ROW_W          = width_of(ROWS)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   frame_data,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [ROWS-1:0]        rows,
  output logic [COLS-1:0]        columns,
  output logic [ROW_W-1:0]       row_idx,
  output logic                   frame_start
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROWS_OFF = {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [COLS-1:0]  COLS_OFF = {COLS{COL_ACTIVE_LOW}};

  scan_state_t                 state;
  logic [ROWS-1:0][COLS-1:0]   display;
  logic [ROWS-1:0][COLS-1:0]   shadow;
  logic                        pending;

  logic                        tc;
  logic                        tmr_clr;
  logic                        tmr_load_blank;
  logic                        tmr_load_dwell;
  logic                        pwm_run;
  logic [BRIGHT_BITS-1:0]      pwm_nxt;

  logic                        accept;
  logic                        boundary;
  logic                        pending_nxt;
  logic [ROW_W-1:0]            row_nxt;
  logic [ROWS-1:0]             rows_on;
  logic [ROWS-1:0]             rows_drv;
  logic [COLS-1:0]             cols_on;
  logic [COLS-1:0]             cols_drv;

  // Timer controls mirror the transitions taken by the state register below.
  always_comb begin
    tmr_clr        = !enable;
    tmr_load_blank = enable && ((state == ST_IDLE) || ((state == ST_ON) && tc));
    tmr_load_dwell = enable && (state == ST_BLANK) && tc;
    pwm_run        = enable && (state == ST_ON);
  end

  led_scan_timer #(
    .DWELL       (DWELL),
    .BLANK       (BLANK),
    .BRIGHT_BITS (BRIGHT_BITS)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (tmr_clr),
    .load_blank (tmr_load_blank),
    .load_dwell (tmr_load_dwell),
    .pwm_run    (pwm_run),
    .tc         (tc),
    .pwm_nxt    (pwm_nxt)
  );

  // Only an empty shadow can accept, so an accept never coincides with a
  // boundary that still has a pending frame to swap in. A frame accepted on
  // the boundary cycle therefore waits for the following boundary.
  assign accept      = frame_valid && frame_ready;
  assign boundary    = enable && (state == ST_ON) && tc && (row_idx == LAST_ROW);
  assign pending_nxt = accept || (pending && !boundary);
  assign row_nxt     = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;

  // Line levels for the coming cycle; pwm_nxt is the phase that cycle will show.
  always_comb begin
    rows_on          = '0;
    rows_on[row_idx] = 1'b1;
    cols_on          = display[row_idx] & {COLS{pwm_nxt < brightness}};
    for (int i = 0; i < ROWS; i++) rows_drv[i] = pol_apply(rows_on[i], ROW_ACTIVE_LOW);
    for (int j = 0; j < COLS; j++) cols_drv[j] = pol_apply(cols_on[j], COL_ACTIVE_LOW);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      display     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_ready <= 1'b1;
      row_idx     <= '0;
      frame_start <= 1'b0;
      rows        <= ROWS_OFF;
      columns     <= COLS_OFF;
    end else begin
      if (accept)              shadow  <= frame_data;
      if (boundary && pending) display <= shadow;
      pending     <= pending_nxt;
      frame_ready <= !pending_nxt;

      frame_start <= 1'b0;
      rows        <= ROWS_OFF;
      columns     <= COLS_OFF;

      if (!enable) begin
        state   <= ST_IDLE;
        row_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state       <= ST_BLANK;
            row_idx     <= '0;
            frame_start <= 1'b1;
          end
          ST_BLANK: begin
            if (tc) begin
              state   <= ST_ON;
              rows    <= rows_drv;
              columns <= cols_drv;
            end
          end
          ST_ON: begin
            if (tc) begin
              state       <= ST_BLANK;
              row_idx     <= row_nxt;
              frame_start <= (row_nxt == '0);
            end else begin
              rows    <= rows_drv;
              columns <= cols_drv;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
